// File: rtl/watch_pkg.sv
// Shared state encoding, default timing and field-step helpers for the
// watch set-mode controller.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_SEC  = 2'b01,
        ST_MIN  = 2'b10,
        ST_HOUR = 2'b11
    } state_e;

    localparam int DEF_REPEAT_DELAY_MS = 500;
    localparam int DEF_REPEAT_RATE_MS  = 100;
    localparam int DEF_TIMEOUT_MS      = 10000;
    localparam int DEF_BLINK_MS        = 250;

    function automatic state_e field_right(input state_e s);
        case (s)
            ST_SEC:  return ST_MIN;
            ST_MIN:  return ST_HOUR;
            default: return ST_SEC;
        endcase
    endfunction

    function automatic state_e field_left(input state_e s);
        case (s)
            ST_SEC:  return ST_HOUR;
            ST_HOUR: return ST_MIN;
            default: return ST_SEC;
        endcase
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge acceptance plus hold-to-repeat for one debounced key level.
// o_raw ignores i_clear so the caller can use it for idle tracking.
module key_repeat
    import watch_pkg::*;
#(
    parameter int DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int RATE_MS  = DEF_REPEAT_RATE_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_enable,
    input  logic i_suppress,
    input  logic i_clear,
    input  logic i_level,
    output logic o_raw,
    output logic o_fire
);

    localparam int MAX_MS = (DELAY_MS > RATE_MS) ? DELAY_MS : RATE_MS;
    localparam int CW     = $clog2(MAX_MS + 1);

    logic          prev_q, prev_d;
    logic          armed_q, armed_d, armed_n;
    logic          rate_q, rate_d, rate_n;
    logic [CW-1:0] cnt_q, cnt_d, cnt_n;
    logic [CW-1:0] cnt_inc, target;
    logic          fire_raw;

    assign cnt_inc = cnt_q + CW'(1);
    assign target  = rate_q ? CW'(RATE_MS) : CW'(DELAY_MS);

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        fire_raw = 1'b0;
        armed_n  = armed_q;
        rate_n   = rate_q;
        cnt_n    = cnt_q;
        if (!i_level || i_suppress || !i_enable) begin
            armed_n = 1'b0;
            rate_n  = 1'b0;
            cnt_n   = '0;
        end else if (!prev_q) begin
            fire_raw = 1'b1;
            armed_n  = 1'b1;
            rate_n   = 1'b0;
            cnt_n    = '0;
        end else if (armed_q && i_tick) begin
            if (cnt_inc == target) begin
                fire_raw = 1'b1;
                rate_n   = 1'b1;
                cnt_n    = '0;
            end else begin
                cnt_n = cnt_inc;
            end
        end
    end

    // A field change or exit to RUN disarms the key and swallows this cycle's pulse.
    always_comb begin
        prev_d  = i_level;
        armed_d = armed_n & ~i_clear;
        rate_d  = rate_n & ~i_clear;
        cnt_d   = i_clear ? '0 : cnt_n;
    end

    assign o_raw  = fire_raw;
    assign o_fire = fire_raw & ~i_clear;

    // NOTE: non-blocking assignments keep all flop updates order-independent.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            rate_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// Watch set-mode controller: RUN/SEC/MIN/HOUR field selection, registered
// adjust pulses with auto-repeat, idle timeout and field blink.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
    parameter int TIMEOUT_MS      = DEF_TIMEOUT_MS,
    parameter int BLINK_MS        = DEF_BLINK_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick_1ms,
    input  logic       i_set_mode,
    input  logic       i_digit_right,
    input  logic       i_digit_left,
    input  logic       i_up_level,
    input  logic       i_down_level,
    output logic       o_sec_up,
    output logic       o_sec_down,
    output logic       o_min_up,
    output logic       o_min_down,
    output logic       o_hour_up,
    output logic       o_hour_down,
    output logic       o_run_en,
    output logic [1:0] o_field_sel,
    output logic       o_blink
);

    localparam int IW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_MS + 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d, idle_next;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;
    logic [5:0]    pulse_q, pulse_d;
    logic          in_set, field_clear;
    logic          up_raw, up_fire, dn_raw, dn_fire;

    assign in_set      = (state_q != ST_RUN);
    assign field_clear = (state_d != state_q);

    key_repeat #(.DELAY_MS(REPEAT_DELAY_MS), .RATE_MS(REPEAT_RATE_MS)) u_up (
        .clk(clk), .rst(rst), .i_tick(i_tick_1ms), .i_enable(in_set),
        .i_suppress(1'b0), .i_clear(field_clear), .i_level(i_up_level),
        .o_raw(up_raw), .o_fire(up_fire)
    );

    // Up wins: a high up level suppresses and disarms the down key.
    key_repeat #(.DELAY_MS(REPEAT_DELAY_MS), .RATE_MS(REPEAT_RATE_MS)) u_down (
        .clk(clk), .rst(rst), .i_tick(i_tick_1ms), .i_enable(in_set),
        .i_suppress(i_up_level), .i_clear(field_clear), .i_level(i_down_level),
        .o_raw(dn_raw), .o_fire(dn_fire)
    );

    always_comb begin
        idle_next = (up_raw || dn_raw) ? '0 : idle_q + IW'(i_tick_1ms);
        state_d   = state_q;
        if (!in_set) begin
            if (i_set_mode) state_d = ST_SEC;
        end else if (i_set_mode) begin
            state_d = ST_RUN;
        end else if (i_digit_right) begin
            state_d = field_right(state_q);
        end else if (i_digit_left) begin
            state_d = field_left(state_q);
        end else if (idle_next == IW'(TIMEOUT_MS)) begin
            state_d = ST_RUN;
        end
        idle_d = (state_d == ST_RUN || field_clear) ? '0 : idle_next;
    end

    always_comb begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (state_d == ST_RUN) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (field_clear) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (i_tick_1ms) begin
            if (bcnt_q + BW'(1) == BW'(BLINK_MS)) begin
                blink_d = ~blink_q;
                bcnt_d  = '0;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        pulse_d = '0;
        case (state_q)
            ST_SEC:  pulse_d[1:0] = {dn_fire, up_fire};
            ST_MIN:  pulse_d[3:2] = {dn_fire, up_fire};
            ST_HOUR: pulse_d[5:4] = {dn_fire, up_fire};
            default: pulse_d      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            idle_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            pulse_q <= pulse_d;
        end
    end

    assign {o_hour_down, o_hour_up, o_min_down, o_min_up, o_sec_down, o_sec_up} = pulse_q;
    assign o_run_en    = (state_q == ST_RUN);
    assign o_field_sel = state_q;
    assign o_blink     = blink_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: directed scenarios then random traffic,
// compared every cycle against a tick-counting behavioural model.
module tb_watch_set_ctrl;

    localparam int DELAY   = 5;
    localparam int RATE    = 2;
    localparam int TIMEOUT = 20;
    localparam int BLINK   = 3;

    typedef struct packed {
        logic [5:0] pulses;   // hour_dn, hour_up, min_dn, min_up, sec_dn, sec_up
        logic       run_en;
        logic [1:0] field;
        logic       blink;
    } obs_t;

    logic clk = 1'b0, rst = 1'b0, i_tick_1ms = 1'b0, i_set_mode = 1'b0;
    logic i_digit_right = 1'b0, i_digit_left = 1'b0, i_up_level = 1'b0, i_down_level = 1'b0;
    logic o_sec_up, o_sec_down, o_min_up, o_min_down, o_hour_up, o_hour_down;
    logic o_run_en, o_blink;
    logic [1:0] o_field_sel;

    always #5 clk = ~clk;

    watch_set_ctrl #(
        .REPEAT_DELAY_MS(DELAY), .REPEAT_RATE_MS(RATE),
        .TIMEOUT_MS(TIMEOUT), .BLINK_MS(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .i_tick_1ms(i_tick_1ms), .i_set_mode(i_set_mode),
        .i_digit_right(i_digit_right), .i_digit_left(i_digit_left),
        .i_up_level(i_up_level), .i_down_level(i_down_level),
        .o_sec_up(o_sec_up), .o_sec_down(o_sec_down), .o_min_up(o_min_up),
        .o_min_down(o_min_down), .o_hour_up(o_hour_up), .o_hour_down(o_hour_down),
        .o_run_en(o_run_en), .o_field_sel(o_field_sel), .o_blink(o_blink)
    );

    obs_t exp_q[$];
    int vectors = 0, miscompares = 0;
    int sec_up_seen = 0, min_up_seen = 0, min_dn_seen = 0, hour_up_seen = 0;

    // Model: state 0=RUN 1=SEC 2=MIN 3=HOUR; held = ticks since accepted edge, -1 when disarmed.
    int m_state = 0, m_up_held = -1, m_dn_held = -1, m_idle = 0, m_bt = 0;
    bit m_prev_up = 0, m_prev_dn = 0;
    bit up_lv = 0, dn_lv = 0;

    function automatic bit is_rep(int n);
        return (n == DELAY) || (n > DELAY && ((n - DELAY) % RATE) == 0);
    endfunction

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step(input bit r, input bit t, input bit s, input bit dr, input bit dl);
        obs_t e;
        bit set, upe, upr, dok, dne, dnr, upf, dnf, chg;
        int nxt, idle_new;
        @(negedge clk);
        rst = r; i_tick_1ms = t; i_set_mode = s; i_digit_right = dr; i_digit_left = dl;
        i_up_level = up_lv; i_down_level = dn_lv;
        e = '0;
        if (r) begin
            m_state = 0; m_up_held = -1; m_dn_held = -1; m_idle = 0; m_bt = 0;
            m_prev_up = 0; m_prev_dn = 0;
            e.run_en = 1'b1;
        end else begin
            set = (m_state != 0);
            upe = set && up_lv && !m_prev_up;
            upr = set && up_lv && m_up_held >= 0 && t && is_rep(m_up_held + 1);
            dok = set && dn_lv && !up_lv;
            dne = dok && !m_prev_dn;
            dnr = dok && m_dn_held >= 0 && t && is_rep(m_dn_held + 1);
            upf = upe || upr;
            dnf = dne || dnr;
            idle_new = (upf || dnf) ? 0 : m_idle + int'(t);
            if (s)             nxt = set ? 0 : 1;
            else if (!set)     nxt = 0;
            else if (dr)       nxt = (m_state == 3) ? 1 : m_state + 1;
            else if (dl)       nxt = (m_state == 1) ? 3 : m_state - 1;
            else if (idle_new >= TIMEOUT) nxt = 0;
            else               nxt = m_state;
            chg = (nxt != m_state);
            if (set && !chg) begin
                if (upf) e.pulses[(m_state - 1) * 2]     = 1'b1;
                if (dnf) e.pulses[(m_state - 1) * 2 + 1] = 1'b1;
            end
            m_idle = (nxt == 0 || chg) ? 0 : idle_new;
            if (!up_lv || !set || chg)              m_up_held = -1;
            else if (upe)                           m_up_held = 0;
            else if (m_up_held >= 0 && t)           m_up_held++;
            if (!dn_lv || up_lv || !set || chg)     m_dn_held = -1;
            else if (dne)                           m_dn_held = 0;
            else if (m_dn_held >= 0 && t)           m_dn_held++;
            m_prev_up = up_lv;
            m_prev_dn = dn_lv;
            if (nxt == 0 || chg) m_bt = 0;
            else                 m_bt += int'(t);
            m_state = nxt;
            e.run_en = (nxt == 0);
            e.field  = 2'(nxt);
            e.blink  = (nxt != 0) && (((m_bt / BLINK) % 2) == 0);
        end
        exp_q.push_back(e);
    endtask

    // Monitor: one expected vector per clock, popped just after the edge it describes.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.pulses = {o_hour_down, o_hour_up, o_min_down, o_min_up, o_sec_down, o_sec_up};
                a.run_en = o_run_en;
                a.field  = o_field_sel;
                a.blink  = o_blink;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got pulses=%b run=%b field=%b blink=%b, want pulses=%b run=%b field=%b blink=%b",
                             $time, a.pulses, a.run_en, a.field, a.blink, e.pulses, e.run_en, e.field, e.blink);
                end
                if (o_sec_up === 1'b1)   sec_up_seen++;
                if (o_min_up === 1'b1)   min_up_seen++;
                if (o_min_down === 1'b1) min_dn_seen++;
                if (o_hour_up === 1'b1)  hour_up_seen++;
            end
        end
    end

    initial begin
        int base, base2;
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Hold up for 12 ticks in SEC: edge pulse plus repeats at ticks 5, 7, 9, 11.
        step(0, 0, 1, 0, 0);
        base = sec_up_seen;
        up_lv = 1; step(0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        end
        up_lv = 0; step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        check("sec_up_repeat_count", sec_up_seen - base, 5);
        check("run_en_in_set", int'(o_run_en), 0);

        // Field stepping with blink toggling between changes.
        for (int k = 0; k < 4; k++) begin
            if (k < 3) step(0, 0, 0, 1, 0);
            else       step(0, 0, 0, 0, 1);
            for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 0);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("field_after_left", int'(o_field_sel), 2);
        check("blink_forced_on_change", int'(o_blink), 1);

        // Up and down together in MIN: up only.
        base = min_up_seen; base2 = min_dn_seen;
        up_lv = 1; dn_lv = 1; step(0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); end
        up_lv = 0; dn_lv = 0; step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        check("min_up_with_both", min_up_seen - base, 5);
        check("min_down_with_both", min_dn_seen - base2, 0);

        // Idle timeout after 20 ticks in SEC.
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 0; k < 19; k++) begin step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); end
        check("field_before_timeout", int'(o_field_sel), 1);
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
        check("field_after_timeout", int'(o_field_sel), 0);
        check("run_en_after_timeout", int'(o_run_en), 1);
        check("blink_after_timeout", int'(o_blink), 0);

        // Key held across set entry yields nothing until re-pressed.
        up_lv = 1; repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        base = sec_up_seen;
        for (int k = 0; k < 10; k++) begin step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); end
        check("held_across_entry", sec_up_seen - base, 0);
        up_lv = 0; step(0, 0, 0, 0, 0);
        up_lv = 1; step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        up_lv = 0; step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
        check("repress_single_pulse", sec_up_seen - base, 1);

        // Reset during a repeat hold in HOUR, on a tick that would otherwise repeat.
        step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 0);
        base = hour_up_seen;
        up_lv = 1; step(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0); end
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
        check("hour_up_before_reset", hour_up_seen - base, 3);
        check("field_after_reset", int'(o_field_sel), 0);
        up_lv = 0;

        // Random traffic.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 9) == 0) up_lv = ~up_lv;
            if ($urandom_range(0, 7) == 0) dn_lv = ~dn_lv;
            step($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 24) == 0);
        end

        repeat (3) begin @(posedge clk); #2; end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
